mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage engine between the EX/MEM register and the MEM/WB register.
- Turns load/store requests into a handshaked data-memory bus transaction, with byte/word sizing and lane steering.
- Stalls upstream while a transaction is pending and inserts bubbles downstream.
- Non-memory instructions pass straight through to MEM/WB with zero added latency.

Parameters:
- TIMEOUT, 16, REQ cycles without mem_ack before abort (>=1)
- TO_W, 5, timeout counter width (must hold TIMEOUT)

Ports:
- CLK  in  1  clock, rising edge
- CLR_N  in  1  reset, synchronous, active-low
- Load_In  in  1  instruction is a load
- Store_In  in  1  instruction is a store
- Size_In  in  1  0=word, 1=byte
- rf_In  in  1  register-file write enable
- Alu_In  in  32  ALU result / effective address
- Store_Data_In  in  32  store data (byte stores use bits [7:0])
- Rd_In  in  4  destination register
- Load_Out  out  1  to MEM/WB
- rf_Out  out  1  to MEM/WB
- Data_Mem_Out  out  32  load data to MEM/WB
- Alu_Out  out  32  to MEM/WB
- Rd_Out  out  4  to MEM/WB
- Stall_Out  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- Fault_Out  out  1  one-cycle pulse on a timed-out access
- mem_req  out  1  bus request, registered
- mem_we  out  1  1=write, registered
- mem_addr  out  32  word-aligned address ([1:0]=00), registered
- mem_be  out  4  byte enables, registered
- mem_wdata  out  32  write data, registered
- mem_ack  in  1  transaction complete, sampled only while mem_req=1
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset (CLR_N=0 at an edge):
  - State to IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, data_q, timeout counter and Fault_Out cleared to 0.
  - While CLR_N=0, combinational outputs are forced: Stall_Out=0, Load_Out=0, rf_Out=0.
  - Reset mid-transaction abandons it; no ack is awaited afterwards.
- Memory op: mem_op = Load_In | Store_In. Load_In and Store_In both high is illegal and is treated as a load.
- FSM IDLE:
  - No mem_op: outputs pass through combinationally (Load_Out=Load_In, rf_Out=rf_In, Alu_Out=Alu_In, Rd_Out=Rd_In, Data_Mem_Out=0); Stall_Out=0.
  - mem_op: Stall_Out=1, Load_Out=0, rf_Out=0 (bubble). At the edge, register mem_req=1, mem_we=Store_In, mem_addr={Alu_In[31:2],2'b00}, mem_be and mem_wdata; go to REQ.
- FSM REQ:
  - Stall_Out=1 and bubble outputs.
  - mem_req and bus fields held stable.
  - Counter increments each cycle.
  - mem_ack=1: latch mem_rdata (steered) into data_q, mem_req drops next cycle, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: drop mem_req, data_q=0, Fault_Out=1 next cycle, go to RESP.
  - Ack and timeout in the same cycle: ack wins, no fault.
- FSM RESP, exactly one cycle:
  - Stall_Out=0.
  - Load_Out, rf_Out, Alu_Out, Rd_Out pass through from the inputs, which are still frozen.
  - Data_Mem_Out=data_q; Fault_Out=1 only on a timeout.
  - Next state IDLE; the next instruction is presented there.
- Sizing, little-endian:
  - Word: mem_be=4'b1111, mem_wdata=Store_Data_In, Data_Mem_Out=mem_rdata.
  - Byte: lane=Alu_In[1:0], mem_be=1<<lane, mem_wdata={4{Store_Data_In[7:0]}}; load data is mem_rdata byte[lane], zero-extended.
  - Misaligned word addresses are silently aligned.
- Stores: Data_Mem_Out=0 in RESP; rf_Out follows rf_In (writeback of a base register is allowed).
- Latency: memory op occupies 1 (IDLE) + N (REQ, ack in the Nth cycle) + 1 (RESP) cycles. Minimum is 3 cycles with a same-cycle ack.
- Back-to-back memory ops: each restarts from IDLE; there is no overlap.

Test Plan:
- ALU op: rf_In=1, Alu_In=0x12345678, Rd_In=5 -> same cycle rf_Out=1, Alu_Out=0x12345678, Rd_Out=5, Stall_Out=0; mem_req stays 0.
- Word load, Alu_In=0x00000042, ack in 3rd REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x40, mem_be=1111; Stall_Out=1 for 4 cycles; RESP shows Load_Out=1, Data_Mem_Out=0xDEADBEEF, Stall_Out=0.
- Byte load, Alu_In=0x43, mem_rdata=0xAABBCCDD -> mem_be=1000, Data_Mem_Out=0x000000AA.
- Byte store, Alu_In=0x41, Store_Data_In=0x1234565A -> mem_we=1, mem_be=0010, mem_wdata=0x5A5A5A5A; RESP Data_Mem_Out=0.
- TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles; RESP has Fault_Out=1 for 1 cycle and Data_Mem_Out=0. Separate run: ack on the 4th cycle -> no fault.
- CLR_N=0 during 2nd REQ cycle -> next edge mem_req=0 and Stall_Out=0; while reset is held, a late mem_ack is ignored; after release, a still-present load reissues from IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns EX/MEM requests into one handshaked data-bus
// transaction, stalls upstream while it is outstanding and bubbles MEM/WB meanwhile.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | pass-through for non-memory ops; a memory op launches the bus request
//  REQ   | mem_req held high, waiting for mem_ack or the timeout
//  RESP  | one cycle presenting the finished memory op (and any fault) to MEM/WB
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        CLK,
    input  logic        CLR_N,
    input  logic        Load_In,
    input  logic        Store_In,
    input  logic        Size_In,
    input  logic        rf_In,
    input  logic [31:0] Alu_In,
    input  logic [31:0] Store_Data_In,
    input  logic [3:0]  Rd_In,
    output logic        Load_Out,
    output logic        rf_Out,
    output logic [31:0] Data_Mem_Out,
    output logic [31:0] Alu_Out,
    output logic [3:0]  Rd_Out,
    output logic        Stall_Out,
    output logic        Fault_Out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              mem_op;
    logic              is_store;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;
    logic              size_q;
    logic [1:0]        lane_q;
    logic [7:0]        rd_byte;
    logic [31:0]       rdata_steer;
    logic [31:0]       data_q;
    logic [TO_W-1:0]   to_cnt;
    logic              to_tc;

    // A simultaneous load+store is illegal and degrades to a load.
    assign mem_op   = Load_In | Store_In;
    assign is_store = Store_In & ~Load_In;

    assign be_nxt    = Size_In ? (4'b0001 << Alu_In[1:0]) : 4'b1111;
    assign wdata_nxt = Size_In ? {4{Store_Data_In[7:0]}} : Store_Data_In;

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            2'd3: rd_byte = mem_rdata[31:24];
            default: rd_byte = mem_rdata[7:0];
        endcase
    end

    assign rdata_steer = size_q ? {24'h0, rd_byte} : mem_rdata;

    // Timeout is a down-counter loaded on launch; zero is the last allowed REQ cycle.
    assign to_tc = (to_cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op) state_nxt = REQ;
            REQ:     if (mem_ack || to_tc) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Alu_Out = Alu_In;
    assign Rd_Out  = Rd_In;

    always_comb begin
        Stall_Out    = 1'b0;
        Load_Out     = 1'b0;
        rf_Out       = 1'b0;
        Data_Mem_Out = 32'h0;
        if (CLR_N) begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        Stall_Out = 1'b1;
                    end else begin
                        Load_Out = Load_In;
                        rf_Out   = rf_In;
                    end
                end
                REQ: begin
                    Stall_Out = 1'b1;
                end
                RESP: begin
                    Load_Out     = Load_In;
                    rf_Out       = rf_In;
                    Data_Mem_Out = data_q;
                end
                default: begin
                    Stall_Out = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            data_q    <= 32'h0;
            to_cnt    <= '0;
            Fault_Out <= 1'b0;
            size_q    <= 1'b0;
            lane_q    <= 2'd0;
        end else begin
            state     <= state_nxt;
            Fault_Out <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {Alu_In[31:2], 2'b00};
                        mem_be    <= be_nxt;
                        mem_wdata <= wdata_nxt;
                        size_q    <= Size_In;
                        lane_q    <= Alu_In[1:0];
                        to_cnt    <= TO_W'(TIMEOUT - 1);
                        data_q    <= 32'h0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        data_q  <= mem_we ? 32'h0 : rdata_steer;
                    end else if (to_tc) begin
                        mem_req   <= 1'b0;
                        data_q    <= 32'h0;
                        Fault_Out <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: cycle-by-cycle table of inputs and hand-computed
// outputs, plus an explicit reset-state check.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic        Load_In, Store_In, Size_In, rf_In;
    logic [31:0] Alu_In, Store_Data_In;
    logic [3:0]  Rd_In;
    logic        Load_Out, rf_Out, Stall_Out, Fault_Out;
    logic [31:0] Data_Mem_Out, Alu_Out;
    logic [3:0]  Rd_Out;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_pass = 0;
    int n_total = 0;

    mem_access_unit #(.TIMEOUT(4), .TO_W(3)) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .Load_In(Load_In), .Store_In(Store_In), .Size_In(Size_In), .rf_In(rf_In),
        .Alu_In(Alu_In), .Store_Data_In(Store_Data_In), .Rd_In(Rd_In),
        .Load_Out(Load_Out), .rf_Out(rf_Out), .Data_Mem_Out(Data_Mem_Out),
        .Alu_Out(Alu_Out), .Rd_Out(Rd_Out), .Stall_Out(Stall_Out), .Fault_Out(Fault_Out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        clr_n, ld, st, sz, rf;
        logic [31:0] alu, sd;
        logic [3:0]  rd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall, e_ld, e_rf, e_fault, e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata, e_dmo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        int unsigned clr_n, int unsigned ld, int unsigned st, int unsigned sz, int unsigned rf,
        int unsigned alu, int unsigned sd, int unsigned rd, int unsigned ack, int unsigned rdata,
        int unsigned stall, int unsigned eld, int unsigned erf, int unsigned eflt, int unsigned ereq,
        int unsigned ewe, int unsigned ebe, int unsigned eaddr, int unsigned ewd, int unsigned edmo);
        vec_t r;
        r.clr_n = 1'(clr_n); r.ld = 1'(ld); r.st = 1'(st); r.sz = 1'(sz); r.rf = 1'(rf);
        r.alu = alu; r.sd = sd; r.rd = 4'(rd); r.ack = 1'(ack); r.rdata = rdata;
        r.e_stall = 1'(stall); r.e_ld = 1'(eld); r.e_rf = 1'(erf); r.e_fault = 1'(eflt);
        r.e_req = 1'(ereq); r.e_we = 1'(ewe); r.e_be = 4'(ebe);
        r.e_addr = eaddr; r.e_wdata = ewd; r.e_dmo = edmo;
        return r;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL row%0d %s: got %h expected %h", row, name, got, exp);
    endtask

    initial begin
        CLR_N = 1'b0; Load_In = 1'b1; Store_In = 1'b1; Size_In = 1'b0; rf_In = 1'b1;
        Alu_In = 32'h44; Store_Data_In = 32'hFFFF_FFFF; Rd_In = 4'd3;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;

        // ALU pass-through, then a word load acked in its 3rd REQ cycle
        tbl.push_back(v(1,0,0,0,1,'h12345678,0,5,0,0,           0,0,1,0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,'hCAFEF00D,0,9,0,0,           0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,1,'h42,0,3,0,0,                 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,1,'h42,0,3,0,0,                 1,0,0,0,1,0,'hF,'h40,0,0));
        tbl.push_back(v(1,1,0,0,1,'h42,0,3,0,0,                 1,0,0,0,1,0,'hF,'h40,0,0));
        tbl.push_back(v(1,1,0,0,1,'h42,0,3,1,'hDEADBEEF,        1,0,0,0,1,0,'hF,'h40,0,0));
        tbl.push_back(v(1,1,0,0,1,'h42,0,3,0,'h11111111,        0,1,1,0,0,0,0,0,0,'hDEADBEEF));
        tbl.push_back(v(1,0,0,0,0,'h7,0,1,0,0,                  0,0,0,0,0,0,0,0,0,0));
        // byte load, lane 3
        tbl.push_back(v(1,1,0,1,1,'h43,0,2,0,0,                 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,1,1,'h43,0,2,1,'hAABBCCDD,        1,0,0,0,1,0,'h8,'h40,0,0));
        tbl.push_back(v(1,1,0,1,1,'h43,0,2,0,0,                 0,1,1,0,0,0,0,0,0,'hAA));
        // byte store, lane 1
        tbl.push_back(v(1,0,1,1,0,'h41,'h1234565A,0,0,0,        1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,1,1,0,'h41,'h1234565A,0,0,0,        1,0,0,0,1,1,'h2,'h40,'h5A5A5A5A,0));
        tbl.push_back(v(1,0,1,1,0,'h41,'h1234565A,0,1,'hFFFFFFFF, 1,0,0,0,1,1,'h2,'h40,'h5A5A5A5A,0));
        tbl.push_back(v(1,0,1,1,0,'h41,'h1234565A,0,0,0,        0,0,0,0,0,0,0,0,0,0));
        // misaligned word store with base writeback
        tbl.push_back(v(1,0,1,0,1,'h1003,'h89ABCDEF,7,0,0,      1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,1,0,1,'h1003,'h89ABCDEF,7,1,0,      1,0,0,0,1,1,'hF,'h1000,'h89ABCDEF,0));
        tbl.push_back(v(1,0,1,0,1,'h1003,'h89ABCDEF,7,0,0,      0,0,1,0,0,0,0,0,0,0));
        // timeout: no ack for 4 REQ cycles
        tbl.push_back(v(1,1,0,0,1,'h80,0,4,0,0,                 1,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1,1,0,0,1,'h80,0,4,0,0,             1,0,0,0,1,0,'hF,'h80,0,0));
        tbl.push_back(v(1,1,0,0,1,'h80,0,4,0,0,                 0,1,1,1,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,0,1,'h99,0,11,0,0,                0,0,1,0,0,0,0,0,0,0));
        // ack in the 4th (last) REQ cycle wins over timeout; byte lane 2
        tbl.push_back(v(1,1,0,1,1,'h82,0,6,0,0,                 1,0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1,1,0,1,1,'h82,0,6,0,0,             1,0,0,0,1,0,'h4,'h80,0,0));
        tbl.push_back(v(1,1,0,1,1,'h82,0,6,1,'h00C30000,        1,0,0,0,1,0,'h4,'h80,0,0));
        tbl.push_back(v(1,1,0,1,1,'h82,0,6,0,0,                 0,1,1,0,0,0,0,0,0,'hC3));
        // load+store together behaves as a load
        tbl.push_back(v(1,1,1,0,1,'h10,'hFFFFFFFF,8,0,0,        1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,0,1,'h10,'hFFFFFFFF,8,1,'h13579BDF, 1,0,0,0,1,0,'hF,'h10,'hFFFFFFFF,0));
        tbl.push_back(v(1,1,1,0,1,'h10,'hFFFFFFFF,8,0,0,        0,1,1,0,0,0,0,0,0,'h13579BDF));
        // back-to-back minimum-latency byte loads
        tbl.push_back(v(1,1,0,1,1,'h01,0,1,0,0,                 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,1,1,'h01,0,1,1,'h0000EE00,        1,0,0,0,1,0,'h2,'h0,0,0));
        tbl.push_back(v(1,1,0,1,1,'h01,0,1,0,0,                 0,1,1,0,0,0,0,0,0,'hEE));
        tbl.push_back(v(1,1,0,1,1,'h01,0,1,0,0,                 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,1,1,'h01,0,1,1,'h0000FF00,        1,0,0,0,1,0,'h2,'h0,0,0));
        tbl.push_back(v(1,1,0,1,1,'h01,0,1,0,0,                 0,1,1,0,0,0,0,0,0,'hFF));
        // reset in the 2nd REQ cycle, late ack during reset, reissue afterwards
        tbl.push_back(v(1,1,0,0,1,'h20,0,2,0,0,                 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,1,'h20,0,2,0,0,                 1,0,0,0,1,0,'hF,'h20,0,0));
        tbl.push_back(v(0,1,0,0,1,'h20,0,2,0,0,                 0,0,0,0,1,0,'hF,'h20,0,0));
        tbl.push_back(v(0,1,0,0,1,'h20,0,2,1,'h55,              0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,0,1,'h20,0,2,1,'h55,              0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,1,'h20,0,2,0,0,                 1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,1,0,0,1,'h20,0,2,1,'hA5A5A5A5,        1,0,0,0,1,0,'hF,'h20,0,0));
        tbl.push_back(v(1,1,0,0,1,'h20,0,2,0,0,                 0,1,1,0,0,0,0,0,0,'hA5A5A5A5));
        tbl.push_back(v(1,0,0,0,0,'h5,0,0,0,0,                  0,0,0,0,0,0,0,0,0,0));

        // reset state, with a load+store and ack driven to show they are ignored
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst mem_req",   -1, 32'(mem_req),   32'h0);
        check("rst mem_we",    -1, 32'(mem_we),    32'h0);
        check("rst mem_be",    -1, 32'(mem_be),    32'h0);
        check("rst mem_addr",  -1, mem_addr,       32'h0);
        check("rst mem_wdata", -1, mem_wdata,      32'h0);
        check("rst fault",     -1, 32'(Fault_Out), 32'h0);
        check("rst stall",     -1, 32'(Stall_Out), 32'h0);
        check("rst load_out",  -1, 32'(Load_Out),  32'h0);
        check("rst rf_out",    -1, 32'(rf_Out),    32'h0);
        check("rst dmem_out",  -1, Data_Mem_Out,   32'h0);
        @(posedge CLK);
        #1;

        for (int r = 0; r < tbl.size(); r++) begin
            CLR_N = tbl[r].clr_n; Load_In = tbl[r].ld; Store_In = tbl[r].st;
            Size_In = tbl[r].sz; rf_In = tbl[r].rf; Alu_In = tbl[r].alu;
            Store_Data_In = tbl[r].sd; Rd_In = tbl[r].rd;
            mem_ack = tbl[r].ack; mem_rdata = tbl[r].rdata;
            @(negedge CLK);
            check("stall",     r, 32'(Stall_Out), 32'(tbl[r].e_stall));
            check("load_out",  r, 32'(Load_Out),  32'(tbl[r].e_ld));
            check("rf_out",    r, 32'(rf_Out),    32'(tbl[r].e_rf));
            check("fault",     r, 32'(Fault_Out), 32'(tbl[r].e_fault));
            check("mem_req",   r, 32'(mem_req),   32'(tbl[r].e_req));
            check("dmem_out",  r, Data_Mem_Out,   tbl[r].e_dmo);
            if (tbl[r].e_req) begin
                check("mem_we",    r, 32'(mem_we), 32'(tbl[r].e_we));
                check("mem_be",    r, 32'(mem_be), 32'(tbl[r].e_be));
                check("mem_addr",  r, mem_addr,    tbl[r].e_addr);
                check("mem_wdata", r, mem_wdata,   tbl[r].e_wdata);
            end
            if (tbl[r].clr_n && !tbl[r].e_stall) begin
                check("alu_out", r, Alu_Out,       tbl[r].alu);
                check("rd_out",  r, 32'(Rd_Out),   32'(tbl[r].rd));
            end
            @(posedge CLK);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
